// File: rtl/i2c_autoread_pkg.sv
// i2c_autoread_pkg: shared FSM states, register field positions and rate table for the auto-read sequencer
package i2c_autoread_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, COLLECT, DONE} state_t;
  localparam int CR_RATE = 13;
  localparam int CR_SAMP = 10;
  localparam int CR_NB = 7;
  localparam int ST_BUSY = 15;
  localparam int ST_OVF = 14;
  localparam int ST_ERR = 13;
  localparam int ST_DONE = 12;
  localparam int ST_TS = 11;
  localparam int CMD_START = 15;
  localparam int CMD_STOP = 14;
  localparam int CMD_RW = 7;
  localparam logic [7:0][11:0] RATE_MULT = {
    12'd3000, 12'd1000, 12'd300, 12'd100, 12'd30, 12'd10, 12'd3, 12'd1
  };
endpackage

// File: rtl/i2c_autoread_fifo.sv
// i2c_autoread_fifo: first-word-fall-through FIFO with level, full/empty and synchronous clear
module i2c_autoread_fifo #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [15:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && cnt_q != '0;
    do_push = push && (!cnt_q[AW] || do_pop);
    wr_d = clr ? '0 : wr_q + AW'(do_push);
    rd_d = clr ? '0 : rd_q + AW'(do_pop);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign level = cnt_q;
  assign full = cnt_q[AW];
  assign empty = cnt_q == '0;
endmodule

// File: rtl/i2c_autoread_seq.sv
// i2c_autoread_seq: periodic multi-byte I2C auto-read into a tagged FIFO; AUTOREAD_TSTAMP_EN adds tick timestamp entries
module i2c_autoread_seq
  import i2c_autoread_pkg::*;
#(
  parameter int FIFO_AW = 8,
  parameter int TB_BASE = 5000,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mode,
  input  logic [9:0]  i2c_adata_out,
  input  logic        i2c_adata_write,
  output logic [15:0] i2c_adata_cmd,
  output logic        i2c_adata_start,
  input  logic [15:0] i2c_adata_cmdreg,
  input  logic        i2c_adata_cmdreg_write,
  output logic [15:0] i2c_adata_status,
  output logic [15:0] i2c_adata_fifo_out,
  input  logic        i2c_adata_fifo_read
);
  state_t state_q, state_d;
  logic [31:0] period_q, period_d, tb_q, tb_d, to_q, to_d;
  logic [6:0] addr_q, addr_d;
  logic [2:0] samp_code_q, samp_code_d, nb_q, nb_d, byte_q, byte_d;
  logic [5:0] samp_q, samp_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic [15:0] cmd_q, cmd_d, fifo_din, fifo_dout, entry;
  logic busy, tick, strobe, timeout, samp_end, last_samp, push, fifo_full, fifo_empty;
  logic [FIFO_AW:0] level;
  assign busy = state_q inside {WAIT_TICK, ISSUE, COLLECT};
  assign tick = busy && tb_q == period_q - 32'd1;
  assign strobe = state_q == COLLECT && i2c_adata_write;
  assign timeout = state_q == COLLECT && !i2c_adata_write && to_q == 32'(TIMEOUT_CYC - 1);
  assign samp_end = timeout || (strobe && (i2c_adata_out[9] || byte_q == nb_q));
  assign last_samp = samp_code_q != 3'd7 && samp_q == 6'((7'd1 << samp_code_q) - 7'd1);
  assign entry = {byte_q == 3'd0, i2c_adata_out[8], samp_q, i2c_adata_out[7:0]};
`ifdef AUTOREAD_TSTAMP_EN
  localparam logic TS_EN = 1'b1;
  logic [15:0] ts_q, ts_d;
  always_comb begin
    ts_d = i2c_adata_cmdreg_write ? 16'd0 : ts_q + 16'(tick);
  end
  always_ff @(posedge clk) begin
    ts_q <= reset ? 16'd0 : ts_d;
  end
  assign push = !i2c_adata_cmdreg_write && (strobe || state_q == ISSUE);
  assign fifo_din = state_q == ISSUE ? ts_q : entry;
`else
  localparam logic TS_EN = 1'b0;
  assign push = !i2c_adata_cmdreg_write && strobe;
  assign fifo_din = entry;
`endif
  i2c_autoread_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (i2c_adata_cmdreg_write),
    .push  (push),
    .pop   (i2c_adata_fifo_read),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    samp_code_d = samp_code_q;
    nb_d = nb_q;
    period_d = period_q;
    tb_d = (busy && !tick) ? tb_q + 32'd1 : '0;
    to_d = (strobe || state_q != COLLECT) ? '0 : to_q + 32'd1;
    samp_d = samp_q;
    byte_d = byte_q;
    cmd_d = cmd_q;
    err_d = err_q | timeout | (strobe & i2c_adata_out[8]);
    ovf_d = ovf_q | (push & fifo_full & ~i2c_adata_fifo_read);
    case (state_q)
      WAIT_TICK: if (tick) begin
        state_d = ISSUE;
        cmd_d = '0;
        cmd_d[CMD_START] = 1'b1;
        cmd_d[CMD_STOP] = 1'b1;
        cmd_d[10:8] = nb_q;
        cmd_d[CMD_RW] = 1'b1;
        cmd_d[6:0] = addr_q;
      end
      ISSUE: state_d = COLLECT;
      COLLECT: begin
        byte_d = samp_end ? 3'd0 : byte_q + 3'(strobe);
        if (samp_end) begin
          samp_d = samp_q + 6'd1;
          state_d = last_samp ? DONE : WAIT_TICK;
        end
      end
      default: ;
    endcase
    if (i2c_adata_cmdreg_write) begin
      addr_d = i2c_adata_cmdreg[6:0];
      nb_d = i2c_adata_cmdreg[CR_NB +: 3];
      samp_code_d = i2c_adata_cmdreg[CR_SAMP +: 3];
      period_d = 32'(TB_BASE) * 32'(RATE_MULT[i2c_adata_cmdreg[CR_RATE +: 3]]);
      tb_d = '0;
      to_d = '0;
      samp_d = '0;
      byte_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
      state_d = i2c_adata_cmdreg[6:0] != 7'd0 ? WAIT_TICK : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      samp_code_q <= '0;
      nb_q <= '0;
      period_q <= '0;
      tb_q <= '0;
      to_q <= '0;
      samp_q <= '0;
      byte_q <= '0;
      cmd_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      samp_code_q <= samp_code_d;
      nb_q <= nb_d;
      period_q <= period_d;
      tb_q <= tb_d;
      to_q <= to_d;
      samp_q <= samp_d;
      byte_q <= byte_d;
      cmd_q <= cmd_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    i2c_adata_status = '0;
    i2c_adata_status[ST_BUSY] = busy;
    i2c_adata_status[ST_OVF] = ovf_q;
    i2c_adata_status[ST_ERR] = err_q;
    i2c_adata_status[ST_DONE] = state_q == DONE;
    i2c_adata_status[ST_TS] = TS_EN;
    i2c_adata_status[8:0] = 9'(level);
  end
  assign mode = busy;
  assign i2c_adata_start = state_q == ISSUE;
  assign i2c_adata_cmd = cmd_q;
  assign i2c_adata_fifo_out = fifo_empty ? 16'd0 : fifo_dout;
endmodule

// File: tb/tb_i2c_autoread_seq.sv
// tb_i2c_autoread_seq: directed self-checking bench for the I2C auto-read sequencer
module tb_i2c_autoread_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode, start;
  logic adata_write = 1'b0;
  logic cmdreg_write = 1'b0;
  logic fifo_read = 1'b0;
  logic [9:0] adata_out = '0;
  logic [15:0] cmd, status, fifo_out;
  logic [15:0] cmdreg = '0;
  logic [15:0] e;
  int checks = 0;
  int failures = 0;
  int nstart = 0;
  int n, base;
  always #5 clk = ~clk;
  always @(posedge clk) if (start) nstart++;
  i2c_autoread_seq #(.FIFO_AW(4), .TB_BASE(20), .TIMEOUT_CYC(200)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .mode                   (mode),
    .i2c_adata_out          (adata_out),
    .i2c_adata_write        (adata_write),
    .i2c_adata_cmd          (cmd),
    .i2c_adata_start        (start),
    .i2c_adata_cmdreg       (cmdreg),
    .i2c_adata_cmdreg_write (cmdreg_write),
    .i2c_adata_status       (status),
    .i2c_adata_fifo_out     (fifo_out),
    .i2c_adata_fifo_read    (fifo_read)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic write_cmd(input logic [15:0] v);
    cmdreg = v;
    cmdreg_write = 1'b1;
    step(1);
    cmdreg_write = 1'b0;
  endtask
  task automatic strobe(input logic [9:0] d, input logic rd);
    adata_out = d;
    adata_write = 1'b1;
    fifo_read = rd;
    step(1);
    adata_write = 1'b0;
    fifo_read = 1'b0;
  endtask
  task automatic pop();
    fifo_read = 1'b1;
    step(1);
    fifo_read = 1'b0;
  endtask
  task automatic wait_start(input int n0, output int nout);
    nout = n0;
    while (!start && nout < n0 + 2000) begin
      @(posedge clk);
      #1;
      nout++;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(3);
    reset = 1'b0;
    chk("rst_mode", mode, 0);
    chk("rst_start", start, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_status", status, 0);
    chk("rst_fifo", fifo_out, 0);
    write_cmd(16'h0177);
    chk("t1_busy", status, 16'h8000);
    chk("t1_mode", mode, 1);
    wait_start(0, n);
    chk("t1_latency", n, 20);
    chk("t1_cmd", cmd, 16'hC2F7);
    step(1);
    chk("t1_pulse", start, 0);
    strobe(10'h0AA, 1'b0);
    strobe(10'h0BB, 1'b0);
    strobe(10'h0CC, 1'b0);
    chk("t1_status", status, 16'h1003);
    chk("t1_mode_done", mode, 0);
    chk("t1_cmd_hold", cmd, 16'hC2F7);
    chk("t1_e0", fifo_out, 16'h80AA);
    pop();
    chk("t1_e1", fifo_out, 16'h00BB);
    pop();
    chk("t1_e2", fifo_out, 16'h00CC);
    pop();
    chk("t1_drained", status, 16'h1000);
    chk("t1_empty", fifo_out, 0);
    write_cmd(16'h2977);
    base = nstart;
    for (int s = 0; s < 4; s++) begin
      wait_start(s == 0 ? 0 : 4, n);
      chk($sformatf("t2_gap%0d", s), n, 60);
      step(1);
      for (int b = 0; b < 3; b++) strobe(10'(s * 16 + b), 1'b0);
    end
    chk("t2_status", status, 16'h100C);
    step(100);
    chk("t2_starts", nstart - base, 4);
    for (int i = 0; i < 12; i++) begin
      e = {i % 3 == 0, 1'b0, 6'(i / 3), 8'((i / 3) * 16 + i % 3)};
      chk($sformatf("t2_entry%0d", i), fifo_out, e);
      pop();
    end
    write_cmd(16'h0BD0);
    for (int s = 0; s < 2; s++) begin
      wait_start(s == 0 ? 0 : 9, n);
      chk($sformatf("t3_start%0d", s), start, 1);
      step(1);
      for (int b = 0; b < 8; b++) strobe(10'(s * 8 + b), 1'b0);
    end
    chk("t3_full", status, 16'h8010);
    chk("t3_head", fifo_out, 16'h8000);
    wait_start(9, n);
    step(1);
    strobe(10'h010, 1'b1);
    chk("t3_pushpop", status, 16'h8010);
    chk("t3_head2", fifo_out, 16'h0001);
    strobe(10'h011, 1'b0);
    strobe(10'h012, 1'b0);
    strobe(10'h213, 1'b0);
    chk("t3_ovf", status, 16'hC010);
    write_cmd(16'h0000);
    chk("t3_stop", status, 16'h0000);
    chk("t3_stop_mode", mode, 0);
    write_cmd(16'h04A2);
    wait_start(0, n);
    chk("t4_latency", n, 20);
    step(1);
    wait_start(1, n);
    chk("t4_timeout_gap", n, 220);
    chk("t4_err", status, 16'hA000);
    step(1);
    strobe(10'h155, 1'b0);
    strobe(10'h266, 1'b0);
    chk("t4_status", status, 16'h3002);
    chk("t4_nack_entry", fifo_out, 16'hC155);
    pop();
    chk("t4_last_entry", fifo_out, 16'h0166);
    write_cmd(16'h0177);
    wait_start(0, n);
    step(1);
    strobe(10'h033, 1'b0);
    chk("t5_one", status, 16'h8001);
    write_cmd(16'h0000);
    chk("t5_abort", status, 16'h0000);
    chk("t5_mode", mode, 0);
    strobe(10'h044, 1'b0);
    strobe(10'h255, 1'b0);
    chk("t5_late", status, 16'h0000);
    chk("t5_late_fifo", fifo_out, 0);
    pop();
    chk("t5_pop_empty", status, 16'h0000);
    write_cmd(16'h0177);
    step(5);
    chk("t6_running", mode, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_mode", mode, 0);
    chk("t6_cmd", cmd, 0);
    chk("t6_status", status, 0);
    chk("t6_start", start, 0);
    chk("t6_fifo", fifo_out, 0);
    base = nstart;
    step(60);
    chk("t6_no_start", nstart - base, 0);
    chk("t6_idle", mode, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_autoread_seq.md
Name: i2c_autoread_seq

Overview:
- Parametrised successor to the single-rate I2C auto-read helper.
- Periodically commands i2c_interface to read N bytes from one slave, repeats for a programmed sample count or continuously, and buffers tagged bytes in an internal FIFO.
- Host reads the FIFO and status through ureg space.
- Drives `mode` high while it owns the i2c_interface command path.

Parameters:
- FIFO_AW, 8: FIFO address width; depth = 2**FIFO_AW entries; legal 4..8.
- TB_BASE, 5000: clk cycles for rate code 0 (0.1 ms at 50 MHz).
- TIMEOUT_CYC, 100000: max cycles between consecutive i2c_adata_write pulses in COLLECT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  out  1  high = autoread owns the i2c_interface command path
- i2c_adata_out  in  10  [7:0] byte, [8] nack, [9] last byte of transaction
- i2c_adata_write  in  1  one-cycle strobe, i2c_adata_out valid
- i2c_adata_cmd  out  16  [15] start, [14] stop, [10:8] nbytes-1, [7] R/W=1, [6:0] addr
- i2c_adata_start  out  1  one-cycle transaction launch pulse
- i2c_adata_cmdreg  in  16  [15:13] rate, [12:10] samples, [9:7] nbytes-1, [6:0] addr
- i2c_adata_cmdreg_write  in  1  cmdreg write strobe; starts or stops a run
- i2c_adata_status  out  16  [15] busy, [14] overflow, [13] error, [12] done, [11:9] 0, [8:0] FIFO level
- i2c_adata_fifo_out  out  16  head entry, first-word-fall-through; 0 when empty
- i2c_adata_fifo_read  in  1  pop strobe

Behaviour:
- Reset:
  - All outputs 0, FSM in IDLE, FIFO empty, sticky flags clear.
- cmdreg_write:
  - Latches all fields, clears FIFO and all flags, clears the timebase counter and sample counter.
  - If addr != 0, go to WAIT_TICK. If addr == 0, go to IDLE (stop).
  - Takes effect from any state, including mid-COLLECT.
  - After an abort, strobes from the in-flight transfer are ignored.
- Timebase:
  - Period = TB_BASE × {1,3,10,30,100,300,1000,3000}[rate].
  - Counter runs 0..period-1 only while busy. `tick` is asserted on the cycle the counter equals period-1.
  - First launch occurs `period` cycles after cmdreg_write.
- Sample count:
  - Codes 0..6 give 2**code samples (1..64).
  - Code 7 means continuous until stopped.
- FSM:
  - IDLE: mode=0. Leaves only on cmdreg_write with addr != 0.
  - WAIT_TICK: mode=1. On tick go to ISSUE.
  - ISSUE: one cycle. i2c_adata_start=1 and i2c_adata_cmd={1,1,3'b0,nbytes-1,1,addr}, both held stable; i2c_adata_cmd stays stable until the next ISSUE. Then go to COLLECT.
  - COLLECT:
    - Each write strobe pushes {first, nack, sample_idx[5:0], byte}. `first`=1 on the first byte of the sample.
    - On bit9=1 or after nbytes bytes: increment the sample counter. If the target is reached go to DONE, else go to WAIT_TICK.
    - nack=1 sets the error flag; collection continues.
    - TIMEOUT_CYC cycles without a strobe: set error, count the sample as done, continue as above.
  - DONE: done=1, mode=0, busy=0. Waits for cmdreg_write.
- Ticks arriving in ISSUE or COLLECT are dropped; samples are never queued.
- FIFO:
  - Push when full: byte dropped, overflow sticky.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo 2**FIFO_AW. Level is FIFO_AW+1 bits, zero-extended into status[8:0].
- busy = state in {WAIT_TICK, ISSUE, COLLECT}.

Optional Feature:
- Macro AUTOREAD_TSTAMP_EN.
- Defined:
  - A free-running 16-bit tick counter runs, cleared on cmdreg_write and incremented on each tick.
  - In ISSUE, the counter value is pushed as a FIFO entry ahead of the sample bytes, subject to the same full/overflow rules.
  - status[11] = 1 signals timestamps are present.
- Undefined:
  - No timestamp entries are pushed and status[11] = 0.

Decomposition:
- Package i2c_autoread_pkg holds:
  - FSM state enum
  - cmdreg field bit positions
  - status bit indices
  - rate multiplier table (8 × 12-bit constants)
  - cmd flag bit positions
- Sub-module i2c_autoread_fifo: synchronous FWFT FIFO parameterised by FIFO_AW, with level output, full/empty, and a synchronous clear.

Test Plan:
- Single sample: TB_BASE=20, cmdreg=0x0177 (rate0, samples0, nbytes=3, addr 0x77) → start pulse at cycle 20 after write, cmd=0xC2F7. After 3 strobes, FIFO level=3, entries 0x80xx/0x00xx/0x00xx, then done=1 and mode=0.
- Four samples at rate1: sample code 2 → exactly 4 start pulses, 60 cycles apart, 12 FIFO entries, sample_idx fields 0..3.
- Overflow: FIFO_AW=4, 20 bytes pushed with no pops → level=16, overflow=1. A simultaneous push+pop while full leaves level=16.
- Timeout and nack: no strobes for TIMEOUT_CYC → error=1 and the next sample launches. A strobe with bit8=1 sets error and its byte is stored with bit14=1.
- Abort: cmdreg_write mid-COLLECT with addr=0 → IDLE and level=0 next cycle. Late strobes leave FIFO empty.
- Reset mid-run: reset during WAIT_TICK → all outputs 0 and no start pulse afterwards.
